pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Program-counter and fetch-control stage that sits directly upstream of the instruction ROM.
- Drives the ROM's combinational address input (prog_ctr) each cycle.
- Sequences the program through start, run and halt, and applies taken branches (relative or absolute) supplied by the decode/branch logic.
- Provides done/running status and a run-cycle counter to the testbench/top level.

Parameters:
- D, 12, program counter / ROM address width.
- START_ADDR, 0, address loaded on reset and on every start.
- OFS_W, 8, width of the signed relative-branch offset.
- CNT_W, 16, width of the cycle counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin (or restart) execution.
- stall  input  1  hold the PC for this cycle (RUN only).
- halt  input  1  decoded halt/done instruction at current prog_ctr.
- br_taken  input  1  branch/jump taken for the instruction at current prog_ctr.
- br_rel  input  1  1: relative branch using br_offset; 0: absolute jump to jmp_target.
- br_offset  input  OFS_W  signed two's-complement PC offset.
- jmp_target  input  D  absolute jump address.
- prog_ctr  output  D  current instruction address to the ROM (registered).
- running  output  1  high while in RUN.
- done  output  1  high while in HALT.
- cycle_cnt  output  CNT_W  number of RUN cycles since last start.

Behaviour:
- Clock and reset: one clock, clk. Reset is reset_n, asynchronous and active-low.
- Reset values: while reset_n=0 (asynchronous assert, synchronous-to-clk deassert assumed externally), state=IDLE, prog_ctr=START_ADDR, running=0, done=0, cycle_cnt=0.
- States: IDLE, RUN, HALT. running = (state==RUN) and done = (state==HALT), both decoded from registered state with no extra latency.
- IDLE:
  - prog_ctr holds; branch, stall and halt inputs are ignored.
  - start=1 -> RUN next edge, with prog_ctr<=START_ADDR and cycle_cnt<=0.
- RUN: per edge, fixed priority halt > stall > br_taken > increment.
  - halt=1 -> HALT; prog_ctr holds (stays on the halt instruction).
  - stall=1 -> prog_ctr holds; state stays RUN.
  - br_taken & br_rel -> prog_ctr <= prog_ctr + sign_extend(br_offset) to D bits, modulo 2^D.
  - br_taken & !br_rel -> prog_ctr <= jmp_target.
  - Otherwise prog_ctr <= prog_ctr + 1, modulo 2^D (2^D-1 wraps to 0; no error flag).
  - cycle_cnt increments on every RUN edge, including stall and halt edges, and saturates at all-ones.
  - start while in RUN is ignored.
- HALT:
  - prog_ctr and cycle_cnt hold; done=1.
  - start=1 -> RUN with prog_ctr<=START_ADDR, cycle_cnt<=0, done drops the same edge.
  - All other inputs are ignored.
- Latency: prog_ctr changes exactly one edge after the controlling inputs are sampled. The ROM output for the new address is valid combinationally in that same following cycle.
- Simultaneous events: halt+br_taken -> halt wins, no redirect. stall+br_taken -> stall wins, branch is lost (upstream must hold br_taken until stall drops). start+halt in IDLE -> start only.
- Reset mid-run: immediate return to IDLE/START_ADDR, with cycle_cnt and done cleared asynchronously.
- Width rules: br_offset sign-extended to D bits before the add; carry out discarded.

Test Plan:
- Reset/idle: hold reset_n=0, then release, with no start for 5 cycles -> prog_ctr=0, running=0, done=0, cycle_cnt=0 throughout.
- Sequential run: pulse start; no branches for 4 cycles -> prog_ctr 0,1,2,3,4 on successive edges; running=1; cycle_cnt=4.
- Branches: at PC=10 apply br_taken, br_rel=1, br_offset=8'hFB -> PC=5. At PC=6 apply br_taken, br_rel=0, jmp_target=12'h0FF -> PC=0x0FF. Hold PC=0x0FF stall=1 for 3 cycles -> PC stays 0x0FF, cycle_cnt still advances by 3.
- Wrap: relative branch to 0xFFF, then one plain cycle -> PC=0x000. At PC=0x002, br_offset=8'h80 -> PC=0xF82.
- Halt/restart: at PC=0x020 assert halt together with br_taken -> next edge done=1, running=0, PC=0x020, cycle_cnt frozen. Pulse start -> PC=0, done=0, cycle_cnt=0.
- Async reset mid-run: drop reset_n between edges while PC=0x033 -> prog_ctr=0 and state IDLE immediately, before the next clk edge.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Program-counter / fetch sequencer feeding the instruction ROM address.
// Tracks IDLE/RUN/HALT, applies relative or absolute branches and counts RUN cycles.
module pc_fetch_ctrl #(
   parameter int unsigned D          = 12,
   parameter int unsigned START_ADDR = 0,
   parameter int unsigned OFS_W      = 8,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic                    stall,
   input  logic                    halt,
   input  logic                    br_taken,
   input  logic                    br_rel,
   input  logic signed [OFS_W-1:0] br_offset,
   input  logic [D-1:0]            jmp_target,
   output logic [D-1:0]            prog_ctr,
   output logic                    running,
   output logic                    done,
   output logic [CNT_W-1:0]        cycle_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   localparam logic [D-1:0] START_PC = D'(START_ADDR);

   state_t           state_q, state_d;
   logic [D-1:0]     pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // The offset is narrower than the PC (D > OFS_W); carry out of the add is dropped.
   function automatic logic [D-1:0] rel_target(input logic [D-1:0]            pc,
                                               input logic signed [OFS_W-1:0] ofs);
      logic signed [D-1:0] ofs_ext;
      ofs_ext = {{(D-OFS_W){ofs[OFS_W-1]}}, ofs};
      return pc + $unsigned(ofs_ext);
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         pc_q    <= START_PC;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               pc_d    = START_PC;
               cnt_d   = '0;
            end
         end
         ST_RUN: begin
            // Counter advances on every RUN edge, stall and halt edges included.
            cnt_d = sat_inc(cnt_q);
            if (halt) begin
               state_d = ST_HALT;
            end else if (stall) begin
               pc_d = pc_q;
            end else if (br_taken) begin
               pc_d = br_rel ? rel_target(pc_q, br_offset) : jmp_target;
            end else begin
               pc_d = pc_q + 1'b1;
            end
         end
         ST_HALT: begin
            if (start) begin
               state_d = ST_RUN;
               pc_d    = START_PC;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            pc_d    = START_PC;
            cnt_d   = '0;
         end
      endcase
   end

   assign prog_ctr  = pc_q;
   assign running   = (state_q == ST_RUN);
   assign done      = (state_q == ST_HALT);
   assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural model of the fetch sequencer.
module tb_pc_fetch_ctrl;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              start, stall, halt, br_taken, br_rel;
   logic signed [7:0] br_offset;
   logic [11:0]       jmp_target;
   logic [11:0]       prog_ctr, prog_ctr_s;
   logic              running, done, running_s, done_s;
   logic [15:0]       cycle_cnt;
   logic [3:0]        cycle_cnt_s;

   int n_checks = 0;
   int n_pass   = 0;

   pc_fetch_ctrl #(.D(12), .START_ADDR(0), .OFS_W(8), .CNT_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .stall(stall), .halt(halt),
      .br_taken(br_taken), .br_rel(br_rel), .br_offset(br_offset), .jmp_target(jmp_target),
      .prog_ctr(prog_ctr), .running(running), .done(done), .cycle_cnt(cycle_cnt)
   );

   // Narrow-counter copy used to reach the saturation point quickly.
   pc_fetch_ctrl #(.D(12), .START_ADDR(0), .OFS_W(8), .CNT_W(4)) dut_s (
      .clk(clk), .reset_n(reset_n), .start(start), .stall(stall), .halt(halt),
      .br_taken(br_taken), .br_rel(br_rel), .br_offset(br_offset), .jmp_target(jmp_target),
      .prog_ctr(prog_ctr_s), .running(running_s), .done(done_s), .cycle_cnt(cycle_cnt_s)
   );

   always #5 clk = ~clk;

   // Behavioural model
   typedef enum {M_IDLE, M_RUN, M_HALT} mstate_t;
   mstate_t m_state;
   int      m_pc, m_cnt, m_cnt_s;

   task automatic model_reset();
      m_state = M_IDLE; m_pc = 0; m_cnt = 0; m_cnt_s = 0;
   endtask

   task automatic model_edge();
      case (m_state)
         M_IDLE: if (start) begin m_state = M_RUN; m_pc = 0; m_cnt = 0; m_cnt_s = 0; end
         M_RUN: begin
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (m_cnt_s < 15) m_cnt_s = m_cnt_s + 1;
            if (halt) m_state = M_HALT;
            else if (stall) m_pc = m_pc;
            else if (br_taken && br_rel) m_pc = ((m_pc + int'(br_offset)) % 4096 + 4096) % 4096;
            else if (br_taken) m_pc = int'(jmp_target);
            else m_pc = (m_pc + 1) % 4096;
         end
         M_HALT: if (start) begin m_state = M_RUN; m_pc = 0; m_cnt = 0; m_cnt_s = 0; end
         default: m_state = M_IDLE;
      endcase
   endtask

   task automatic clear_inputs();
      start = 0; stall = 0; halt = 0; br_taken = 0; br_rel = 0; br_offset = 0; jmp_target = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      clear_inputs();
      model_reset();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if ({prog_ctr, running, done, cycle_cnt} !== 30'd0)
            $display("FAIL reset_hold: pc=%h run=%b done=%b cnt=%0d, want all zero", prog_ctr, running, done, cycle_cnt);
         else n_pass++;
      end
      @(negedge clk); reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if ({prog_ctr, running, done, cycle_cnt} !== 30'd0)
            $display("FAIL idle_hold: pc=%h run=%b done=%b cnt=%0d, want all zero", prog_ctr, running, done, cycle_cnt);
         else n_pass++;
      end
   endtask

   task automatic test_sequential();
      start = 1; halt = 1;            // start+halt in IDLE behaves as start alone
      tick();
      start = 0; halt = 0;
      n_checks++;
      if (prog_ctr !== 12'd0 || running !== 1'b1 || done !== 1'b0 || cycle_cnt !== 16'd0)
         $display("FAIL seq_start: pc=%h run=%b done=%b cnt=%0d, want pc=0 run=1 done=0 cnt=0", prog_ctr, running, done, cycle_cnt);
      else n_pass++;
      for (int i = 1; i <= 4; i++) begin
         tick();
         n_checks++;
         if (prog_ctr !== 12'(i) || cycle_cnt !== 16'(i) || cycle_cnt_s !== 4'(i) || running !== 1'b1)
            $display("FAIL seq_step%0d: pc=%h cnt=%0d cnt_s=%0d run=%b, want pc=%h cnt=%0d", i, prog_ctr, cycle_cnt, cycle_cnt_s, running, 12'(i), i);
         else n_pass++;
      end
      start = 1;                       // ignored while running
      tick();
      start = 0;
      n_checks++;
      if (prog_ctr !== 12'd5 || cycle_cnt !== 16'd5)
         $display("FAIL start_in_run: pc=%h cnt=%0d, want pc=005 cnt=5", prog_ctr, cycle_cnt);
      else n_pass++;
   endtask

   task automatic test_branches();
      int cnt0;
      for (int i = 0; i < 20 && prog_ctr != 12'd10; i++) tick();
      n_checks++;
      if (prog_ctr !== 12'd10) $display("FAIL reach_pc10: pc=%h, want 00a", prog_ctr);
      else n_pass++;
      br_taken = 1; br_rel = 1; br_offset = 8'hFB;
      tick();
      clear_inputs();
      n_checks++;
      if (prog_ctr !== 12'd5) $display("FAIL rel_back: pc=%h, want 005", prog_ctr);
      else n_pass++;
      tick();
      br_taken = 1; br_rel = 0; jmp_target = 12'h0FF;
      tick();
      clear_inputs();
      n_checks++;
      if (prog_ctr !== 12'h0FF) $display("FAIL abs_jump: pc=%h, want 0ff", prog_ctr);
      else n_pass++;
      cnt0 = m_cnt;
      stall = 1; br_taken = 1; jmp_target = 12'h555;  // stall beats the branch
      for (int i = 0; i < 3; i++) begin
         tick();
         br_taken = 0;
      end
      clear_inputs();
      n_checks++;
      if (prog_ctr !== 12'h0FF || cycle_cnt !== 16'(cnt0 + 3))
         $display("FAIL stall_hold: pc=%h cnt=%0d, want pc=0ff cnt=%0d", prog_ctr, cycle_cnt, cnt0 + 3);
      else n_pass++;
      n_checks++;
      if (cycle_cnt_s !== 4'(m_cnt_s) || m_cnt_s != 15)
         $display("FAIL cnt_saturate: cnt_s=%0d, want %0d (saturated 15)", cycle_cnt_s, m_cnt_s);
      else n_pass++;
   endtask

   task automatic test_wrap();
      br_taken = 1; jmp_target = 12'h003;
      tick();
      br_rel = 1; br_offset = -8'sd4;
      tick();
      clear_inputs();
      n_checks++;
      if (prog_ctr !== 12'hFFF) $display("FAIL rel_to_fff: pc=%h, want fff", prog_ctr);
      else n_pass++;
      tick();
      n_checks++;
      if (prog_ctr !== 12'h000) $display("FAIL wrap_inc: pc=%h, want 000", prog_ctr);
      else n_pass++;
      tick(); tick();
      br_taken = 1; br_rel = 1; br_offset = 8'h80;
      tick();
      clear_inputs();
      n_checks++;
      if (prog_ctr !== 12'hF82) $display("FAIL rel_min_ofs: pc=%h, want f82", prog_ctr);
      else n_pass++;
   endtask

   task automatic test_halt_restart();
      int cnt_h;
      br_taken = 1; jmp_target = 12'h020;
      tick();
      halt = 1; br_taken = 1; br_rel = 0; jmp_target = 12'h400;
      tick();
      clear_inputs();
      cnt_h = m_cnt;
      n_checks++;
      if (done !== 1'b1 || running !== 1'b0 || prog_ctr !== 12'h020)
         $display("FAIL halt_enter: done=%b run=%b pc=%h, want done=1 run=0 pc=020", done, running, prog_ctr);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         stall = 1'($urandom); halt = 1'($urandom); br_taken = 1'($urandom);
         br_rel = 1'($urandom); br_offset = 8'($urandom); jmp_target = 12'($urandom);
         tick();
      end
      clear_inputs();
      n_checks++;
      if (prog_ctr !== 12'h020 || cycle_cnt !== 16'(cnt_h) || done !== 1'b1)
         $display("FAIL halt_frozen: pc=%h cnt=%0d done=%b, want pc=020 cnt=%0d done=1", prog_ctr, cycle_cnt, done, cnt_h);
      else n_pass++;
      start = 1;
      tick();
      start = 0;
      n_checks++;
      if (prog_ctr !== 12'h000 || done !== 1'b0 || running !== 1'b1 || cycle_cnt !== 16'd0)
         $display("FAIL restart: pc=%h done=%b run=%b cnt=%0d, want pc=000 done=0 run=1 cnt=0", prog_ctr, done, running, cycle_cnt);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      br_taken = 1; jmp_target = 12'h033;
      tick();
      clear_inputs();
      n_checks++;
      if (prog_ctr !== 12'h033) $display("FAIL reach_033: pc=%h, want 033", prog_ctr);
      else n_pass++;
      @(negedge clk); #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if (prog_ctr !== 12'h000 || running !== 1'b0 || done !== 1'b0 || cycle_cnt !== 16'd0)
         $display("FAIL async_reset: pc=%h run=%b done=%b cnt=%0d, want all zero before edge", prog_ctr, running, done, cycle_cnt);
      else n_pass++;
      @(negedge clk); reset_n = 1'b1;
   endtask

   task automatic test_random();
      int errs = 0;
      for (int i = 0; i < 800; i++) begin
         start      = ($urandom_range(15) == 0);
         halt       = ($urandom_range(24) == 0);
         stall      = ($urandom_range(5) == 0);
         br_taken   = ($urandom_range(3) == 0);
         br_rel     = 1'($urandom);
         br_offset  = 8'($urandom);
         jmp_target = 12'($urandom);
         tick();
         n_checks++;
         if (prog_ctr !== 12'(m_pc) || running !== (m_state == M_RUN) || done !== (m_state == M_HALT) ||
             cycle_cnt !== 16'(m_cnt) || cycle_cnt_s !== 4'(m_cnt_s)) begin
            if (errs < 20)
               $display("FAIL random_c%0d: pc=%h run=%b done=%b cnt=%0d cnt_s=%0d, want pc=%h run=%b done=%b cnt=%0d cnt_s=%0d",
                        i, prog_ctr, running, done, cycle_cnt, cycle_cnt_s, 12'(m_pc), m_state == M_RUN,
                        m_state == M_HALT, m_cnt, m_cnt_s);
            errs++;
         end else n_pass++;
      end
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branches();
      test_wrap();
      test_halt_restart();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
